// File: rtl/mp_add_sequencer.sv
// Multi-precision add controller: steps an external 32-bit adder over WORDS words,
// chaining carry-out to carry-in, and hands the full-width sum out over valid/ready.
module mp_add_sequencer #(
   parameter int unsigned WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORDS*32-1:0]   OpA,
   input  logic [WORDS*32-1:0]   OpB,
   input  logic                  OpCin,
   output logic [31:0]           AddA,
   output logic [31:0]           AddB,
   output logic                  AddCin,
   input  logic [31:0]           AddS,
   input  logic                  AddCout,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORDS*32-1:0]   Sum,
   output logic                  Cout
);

   localparam int unsigned W  = 32;
   localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WORDS-1:0][W-1:0] rega_q;
   logic [WORDS-1:0][W-1:0] regb_q;
   logic [WORDS-1:0][W-1:0] sum_q;
   logic [IW-1:0]           idx_q;
   logic                    carry_q;
   logic                    cout_q;
   logic                    last_word;

   assign last_word = (idx_q == IW'(WORDS - 1));
   assign Sum       = sum_q;
   assign Cout      = cout_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, handshake flags and adder operand muxing
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      AddA      = '0;
      AddB      = '0;
      AddCin    = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = RUN;
            end
         end
         RUN: begin
            AddA   = rega_q[idx_q];
            AddB   = regb_q[idx_q];
            AddCin = carry_q;
            if (last_word) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operand capture, per-word sum write-back and carry chaining
   always_ff @(posedge clk) begin
      if (rst) begin
         rega_q  <= '0;
         regb_q  <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  rega_q  <= OpA;
                  regb_q  <= OpB;
                  carry_q <= OpCin;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               sum_q[idx_q] <= AddS;
               carry_q      <= AddCout;
               idx_q        <= IW'(idx_q + IW'(1));
               if (last_word) begin
                  cout_q <= AddCout;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/mp_add_sequencer.md
Name: mp_add_sequencer

Overview:
- Multi-precision add controller that drives the 32-bit Kogge-Stone adder one word per cycle. It chains the adder's Cout back into Cin so that WORDS*32-bit operands are summed.
- Sits directly around the adder:
  - It feeds A/B/Cin to the adder.
  - It consumes S/Cout from the adder.
  - It presents the full-width sum to downstream logic over a valid/ready handshake.
- The adder stays purely combinational and external to this block.

Parameters:
WORDS, 4, number of 32-bit words per operand (>=2); operand width N = WORDS*32

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand set valid
in_ready  out  1  block can accept operands
OpA  in  N  operand A
OpB  in  N  operand B
OpCin  in  1  carry-in of the full-width add
AddA  out  32  to adder A (current word of OpA)
AddB  out  32  to adder B (current word of OpB)
AddCin  out  1  to adder Cin (chained carry)
AddS  in  32  from adder S
AddCout  in  1  from adder Cout
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
Sum  out  N  full-width sum
Cout  out  1  full-width carry-out

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled at the rising edge.
- Reset values:
  - State = IDLE.
  - in_ready=1, out_valid=0.
  - Sum=0, Cout=0.
  - Word index=0, carry register=0.
  - Operand registers=0.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch OpA, OpB and OpCin into registers, set index=0, set carry=OpCin, go to RUN.
  - Operands are sampled only at the accept edge; later changes on OpA/OpB/OpCin are ignored.
- RUN:
  - in_ready=0.
  - Combinationally: AddA = regA[32*idx +: 32], AddB = regB[32*idx +: 32], AddCin = carry.
  - At each edge: Sum[32*idx +: 32] <= AddS, carry <= AddCout, idx <= idx+1.
  - At the edge where idx==WORDS-1: Cout <= AddCout, go to DONE.
  - Adder latency is zero, so each word is one cycle.
- DONE:
  - out_valid=1, in_ready=0.
  - Sum and Cout are held stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1: go to IDLE and clear out_valid.
  - in_valid is ignored in DONE; acceptance only happens in IDLE.
- AddA, AddB and AddCin are 0 in IDLE and in DONE.
- Latency: out_valid rises exactly WORDS cycles after the accept edge.
- Throughput: with out_ready tied high and in_valid held high, one result every WORDS+2 cycles.
- Sum words not yet written in the current transaction keep their old contents. They are not visible externally because out_valid=0.
- Arithmetic is modulo 2^N. Cout is bit N of OpA+OpB+OpCin.
- Reset mid-operation (in RUN or DONE): the rst edge forces the full reset state. A partial result is never presented.
- rst has priority over every handshake in the same cycle.

Test Plan:
- Multi-word carry ripple (WORDS=4):
  - Stimulus: OpA=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, OpB=1, OpCin=0.
  - Required: Sum=0x0000_0000_0000_0001_0000_0000_0000_0000, Cout=0, out_valid 4 cycles after accept.
- Full wrap:
  - Stimulus: OpA=all ones (128 bits), OpB=0, OpCin=1.
  - Required: Sum=0, Cout=1. AddCin observed =1 in all 4 RUN cycles.
- Per-word complement:
  - Stimulus: every word of OpA=0xFFFF0000, every word of OpB=0x0000FFFF, OpCin=1.
  - Required: Sum=0, Cout=1. AddS=0x00000000 and AddCout=1 each RUN cycle.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid; in_valid=1 with new operands during that time.
  - Required: Sum/Cout stable, in_ready=0, new operands not accepted. The handshake on cycle 6 returns to IDLE, and the new operands are accepted on the following edge.
- Reset mid-RUN:
  - Stimulus: assert rst for 1 cycle after 2 RUN cycles.
  - Required: next cycle state is IDLE, in_ready=1, out_valid=0, Sum=0, Cout=0. A subsequent transaction gives the correct result.
- Back-to-back:
  - Stimulus: in_valid and out_ready tied high; three random operand sets fed in turn.
  - Required: results match a reference model of OpA+OpB+OpCin, with out_valid pulses exactly 6 cycles apart.
